// File: rtl/mm_job_sequencer_pkg.sv
// Shared types and address/size helpers for the matrix-multiply job sequencer.
package mm_job_sequencer_pkg;

  // Job phases of the sequencer
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // C is written by the multiplier over the A region
  localparam int unsigned C_BASE = 0;

  // Output buffer depth used for read-issue gating
  localparam int unsigned OUT_BUF_DEPTH = 2;

  // Matrix row/column length for a given log2 dimension
  function automatic int unsigned vec_size(input int unsigned l);
    return 32'd1 << l;
  endfunction

  // Words per matrix for a given log2 dimension
  function automatic int unsigned mat_size(input int unsigned l);
    return 32'd1 << (32'd2 * l);
  endfunction

  // B follows A directly in BRAM
  function automatic int unsigned b_base(input int unsigned l);
    return mat_size(l);
  endfunction

endpackage

// File: rtl/mm_job_sequencer_out_buf.sv
// Two-entry output FIFO decoupling BRAM read returns from the output stream.
module mm_out_buf #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mm_job_sequencer.sv
// Job controller: loads A/B into BRAM, runs the multiplier, streams C back out.
module mm_job_sequencer
  import mm_job_sequencer_pkg::*;
#(
  parameter int unsigned L_RAM_SIZE = 3,
  parameter int unsigned BITWIDTH   = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [BITWIDTH-1:0]     s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [BITWIDTH-1:0]     m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [2*L_RAM_SIZE:0]   bram_addr,
  output logic                    bram_we,
  output logic [BITWIDTH-1:0]     bram_wrdata,
  input  logic [BITWIDTH-1:0]     bram_rddata,
  output logic                    mm_start,
  input  logic [2*L_RAM_SIZE:0]   mm_addr,
  input  logic                    mm_we,
  input  logic [BITWIDTH-1:0]     mm_wrdata,
  input  logic                    mm_done,
  output logic [BITWIDTH-1:0]     mm_rddata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned AW        = 2 * L_RAM_SIZE + 1;
  localparam int unsigned MAT_SIZE  = mat_size(L_RAM_SIZE);
  localparam int unsigned LOAD_LAST = b_base(L_RAM_SIZE) + MAT_SIZE - 1;
  localparam int unsigned BUF_W     = BITWIDTH + 1;

  state_e             state_q;
  state_e             state_d;
  logic [AW-1:0]      load_cnt_q;
  logic [AW-1:0]      drain_cnt_q;
  logic [AW-1:0]      addr_q;
  logic               we_q;
  logic [BITWIDTH-1:0] wrdata_q;
  logic               addr_vld_q;
  logic               addr_last_q;
  logic               ret_q;
  logic               ret_last_q;
  logic               err_q;

  logic               s_hs;
  logic               load_final;
  logic               issue;
  logic [2:0]         outstanding;
  logic               last_hs;

  logic [1:0]         buf_count;
  logic               buf_in_ready;
  logic [BUF_W-1:0]   buf_out;

  assign s_hs        = s_tvalid && (state_q == ST_LOAD);
  assign load_final  = s_hs && (load_cnt_q == AW'(LOAD_LAST));
  assign outstanding = 3'(buf_count) + 3'(addr_vld_q) + 3'(ret_q);
  // Reads start on the first mm_done cycle so data lands 2 cycles into DRAIN
  assign issue       = (((state_q == ST_RUN) && mm_done) || (state_q == ST_DRAIN))
                       && (drain_cnt_q < AW'(MAT_SIZE))
                       && (outstanding < 3'(OUT_BUF_DEPTH))
                       && buf_in_ready;
  assign last_hs     = m_tvalid && m_tready && m_tlast;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded control outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    s_tready  = 1'b0;
    mm_start  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s_tready = 1'b1;
        if (load_final) state_d = ST_START;
      end
      ST_START: begin
        mm_start = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (mm_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_hs) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, registered BRAM port, read pipeline tracking and framing error
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wrdata_q    <= '0;
      addr_vld_q  <= 1'b0;
      addr_last_q <= 1'b0;
      ret_q       <= 1'b0;
      ret_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      addr_vld_q  <= issue;
      addr_last_q <= issue && (drain_cnt_q == AW'(MAT_SIZE - 1));
      ret_q       <= addr_vld_q;
      ret_last_q  <= addr_last_q;
      case (state_q)
        ST_IDLE: begin
          load_cnt_q  <= '0;
          drain_cnt_q <= '0;
          if (cmd_valid) err_q <= 1'b0;
        end
        ST_LOAD: begin
          if (s_hs) begin
            we_q     <= 1'b1;
            addr_q   <= load_cnt_q;
            wrdata_q <= s_tdata;
            if (load_final) begin
              err_q <= err_q | ~s_tlast;
            end else begin
              err_q      <= err_q | s_tlast;
              load_cnt_q <= load_cnt_q + AW'(1);
            end
          end
        end
        default: ;
      endcase
      if (issue) begin
        addr_q      <= AW'(C_BASE) + drain_cnt_q;
        drain_cnt_q <= drain_cnt_q + AW'(1);
      end
    end
  end

  // Multiplier owns the BRAM port combinationally while it runs
  assign bram_addr   = (state_q == ST_RUN) ? mm_addr   : addr_q;
  assign bram_we     = (state_q == ST_RUN) ? mm_we     : we_q;
  assign bram_wrdata = (state_q == ST_RUN) ? mm_wrdata : wrdata_q;
  assign mm_rddata   = bram_rddata;
  assign err         = err_q;

  mm_out_buf #(
    .WIDTH(BUF_W)
  ) u_out_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({ret_last_q, bram_rddata}),
    .in_valid  (ret_q),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .count     (buf_count)
  );

  assign m_tlast = buf_out[BITWIDTH];
  assign m_tdata = buf_out[BITWIDTH-1:0];

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Self-checking bench for mm_job_sequencer with a BRAM model and a behavioural multiplier.
module tb_mm_job_sequencer;

  localparam int unsigned L   = 3;
  localparam int unsigned BW  = 32;
  localparam int unsigned VEC = 8;
  localparam int unsigned MAT = 64;
  localparam int unsigned NW  = 128;
  localparam int unsigned AW  = 7;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid, cmd_ready;
  logic [BW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [BW-1:0] bram_wrdata, bram_rddata;
  logic          mm_start;
  logic [AW-1:0] mm_addr;
  logic          mm_we;
  logic [BW-1:0] mm_wrdata, mm_rddata;
  logic          mm_done, busy, done, err;

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] wa   [NW];
  logic [BW-1:0] expc [MAT];
  logic [BW-1:0] mem  [NW];
  logic [BW-1:0] rd_q;

  always #5 aclk = ~aclk;

  mm_job_sequencer #(.L_RAM_SIZE(L), .BITWIDTH(BW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wrdata(bram_wrdata),
    .bram_rddata(bram_rddata),
    .mm_start(mm_start), .mm_addr(mm_addr), .mm_we(mm_we), .mm_wrdata(mm_wrdata),
    .mm_done(mm_done), .mm_rddata(mm_rddata),
    .busy(busy), .done(done), .err(err)
  );

  // Single-port BRAM with one-cycle read latency
  always @(posedge aclk) begin
    if (bram_we) mem[bram_addr] <= bram_wrdata;
    rd_q <= mem[bram_addr];
  end
  assign bram_rddata = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A row-major then B row-major; C = A*B modulo 2^32
  task automatic make_stimulus(input bit identity);
    logic [BW-1:0] acc;
    for (int i = 0; i < int'(MAT); i++) begin
      wa[i]       = identity ? ((i / VEC == i % VEC) ? 32'd1 : 32'd0) : BW'($urandom_range(0, 1000));
      wa[MAT + i] = identity ? BW'(i + 1) : BW'($urandom);
    end
    for (int r = 0; r < int'(VEC); r++) begin
      for (int c = 0; c < int'(VEC); c++) begin
        acc = '0;
        for (int k = 0; k < int'(VEC); k++) acc = acc + wa[r * VEC + k] * wa[MAT + k * VEC + c];
        expc[r * VEC + c] = acc;
      end
    end
  endtask

  // frame_mode: 0 clean, 1 extra tlast on word 10, 2 tlast missing on last word
  task automatic run_job(input bit bursty, input int frame_mode, input bit hold_cmd);
    int  k, n, cyc, first_cyc;
    bit  to, hs_prev, stalled, err_exp;
    logic [BW-1:0] held;
    err_exp = (frame_mode != 0);
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    to = (cyc >= 50);
    chk("cmd_wait_timeout", 64'(to), 64'(0));
    cmd_valid = 1'b1;
    @(negedge aclk);
    chk("accept_busy", 64'(busy), 64'(1));
    chk("accept_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("accept_err_clear", 64'(err), 64'(0));
    if (!hold_cmd) cmd_valid = 1'b0;

    k = 0; cyc = 0; hs_prev = 1'b0;
    while (k < int'(NW) && cyc < 2000) begin
      chk("load_we", 64'(bram_we), 64'(hs_prev));
      if (hs_prev) begin
        chk("load_addr", 64'(bram_addr), 64'(k - 1));
        chk("load_data", 64'(bram_wrdata), 64'(wa[k - 1]));
      end
      mm_we     = 1'($urandom_range(0, 1));
      mm_addr   = AW'($urandom);
      mm_wrdata = BW'($urandom);
      s_tvalid  = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata   = s_tvalid ? wa[k] : BW'($urandom);
      s_tlast   = (k == int'(NW) - 1) ? (frame_mode != 2) : (frame_mode == 1 && k == 10);
      hs_prev   = s_tvalid && s_tready;
      if (hs_prev) k++;
      @(negedge aclk);
      cyc++;
    end
    to = (cyc >= 2000);
    chk("load_timeout", 64'(to), 64'(0));
    if (to) return;
    chk("last_write_we", 64'(bram_we), 64'(1));
    chk("last_write_addr", 64'(bram_addr), 64'(NW - 1));
    chk("mm_start_pulse", 64'(mm_start), 64'(1));
    chk("start_s_tready", 64'(s_tready), 64'(0));
    s_tvalid = 1'b0; s_tlast = 1'b0; mm_we = 1'b0;
    @(negedge aclk);
    chk("mm_start_single", 64'(mm_start), 64'(0));
    for (int i = 0; i < int'(NW); i++) chk("bram_loaded", 64'(mem[i]), 64'(wa[i]));

    // Behavioural multiplier: write C through the borrowed port, then hold done
    repeat ($urandom_range(0, 5)) @(negedge aclk);
    for (int i = 0; i < int'(MAT); i++) begin
      mm_addr = AW'(i); mm_we = 1'b1; mm_wrdata = expc[i];
      #1;
      chk("run_pass_we", 64'(bram_we), 64'(1));
      chk("run_pass_addr", 64'(bram_addr), 64'(i));
      chk("run_pass_data", 64'(bram_wrdata), 64'(expc[i]));
      @(negedge aclk);
    end
    chk("mm_rddata_mirror", 64'(mm_rddata), 64'(bram_rddata));
    mm_we = 1'b0; mm_done = 1'b1;

    n = 0; cyc = 0; stalled = 1'b0; first_cyc = -1; held = '0;
    while (n < int'(MAT) && cyc < 2000) begin
      @(negedge aclk);
      cyc++;
      if (cyc >= 3) mm_done = 1'b0;
      if (m_tvalid && first_cyc < 0) first_cyc = cyc;
      if (stalled) begin
        chk("stall_valid", 64'(m_tvalid), 64'(1));
        chk("stall_data", 64'(m_tdata), 64'(held));
      end
      chk("drain_we", 64'(bram_we), 64'(0));
      m_tready = bursty ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (m_tvalid && m_tready) begin
        chk("out_data", 64'(m_tdata), 64'(expc[n]));
        chk("out_last", 64'(m_tlast), 64'(n == int'(MAT) - 1));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = m_tvalid;
        held    = m_tdata;
      end
    end
    to = (cyc >= 2000);
    chk("drain_timeout", 64'(to), 64'(0));
    if (!bursty) chk("first_out_latency", 64'(first_cyc), 64'(3));
    @(negedge aclk);
    m_tready = 1'b0;
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(1));
    chk("done_no_accept", 64'(cmd_ready), 64'(0));
    chk("job_err", 64'(err), 64'(err_exp));
    @(negedge aclk);
    chk("done_single", 64'(done), 64'(0));
    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'(0));
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({tag, "_m_tlast"}, 64'(m_tlast), 64'(0));
    chk({tag, "_m_tdata"}, 64'(m_tdata), 64'(0));
    chk({tag, "_bram_addr"}, 64'(bram_addr), 64'(0));
    chk({tag, "_bram_we"}, 64'(bram_we), 64'(0));
    chk({tag, "_bram_wrdata"}, 64'(bram_wrdata), 64'(0));
    chk({tag, "_mm_start"}, 64'(mm_start), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
  endtask

  initial begin
    int k;
    aresetn = 1'b0; cmd_valid = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b0; mm_addr = '0; mm_we = 1'b0; mm_wrdata = '0; mm_done = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("rst");
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check_reset_outputs("post_rst");

    // Identity A, B = 1..64, free-flowing output
    make_stimulus(1'b1);
    run_job(1'b0, 0, 1'b0);

    // Random matrices with bursty input and output backpressure
    make_stimulus(1'b0);
    run_job(1'b1, 0, 1'b0);

    // Framing errors
    make_stimulus(1'b0);
    run_job(1'b0, 1, 1'b0);
    make_stimulus(1'b1);
    run_job(1'b1, 2, 1'b0);

    // Abort during word 40 of LOAD, then a fresh job
    make_stimulus(1'b0);
    cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    k = 0;
    while (k < 40) begin
      s_tvalid = 1'b1; s_tdata = wa[k]; s_tlast = 1'b0;
      @(negedge aclk);
      k++;
    end
    s_tdata = wa[40];
    #2 aresetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    s_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    check_reset_outputs("abort_rel");
    make_stimulus(1'b0);
    run_job(1'b1, 0, 1'b0);

    // Back-to-back jobs with cmd_valid held across the boundary
    make_stimulus(1'b1);
    run_job(1'b0, 0, 1'b1);
    make_stimulus(1'b0);
    run_job(1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
